// File: rtl/nn_pkg.sv
// Shared types and widths for the step scheduler: FSM state encoding and
// the fixed widths of the owner and step outputs.
package nn_pkg;

   localparam int STEP_W  = 5;
   localparam int OWNER_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/nn_step_scheduler_if.sv
// Requester-side bus of the step scheduler: level requests and hold in,
// grant, owner index, step sequencing and completion pulses out.
interface nn_step_scheduler_if #(
   parameter int NUM_REQ = 4
) ();

   logic [NUM_REQ-1:0]         req;
   logic                       hold;
   logic [NUM_REQ-1:0]         gnt;
   logic [nn_pkg::OWNER_W-1:0] owner;
   logic [nn_pkg::STEP_W-1:0]  step;
   logic                       step_valid;
   logic                       done;
   logic                       aborted;

   // Requester side: drives requests and hold, observes the sequencer.
   modport master (
      output req, hold,
      input  gnt, owner, step, step_valid, done, aborted
   );

   // Scheduler side.
   modport slave (
      input  req, hold,
      output gnt, owner, step, step_valid, done, aborted
   );

endinterface

// File: rtl/nn_rr_pick.sv
// Combinational winner selection: lowest set request at or above the
// pointer, wrapping to the lowest set request overall. A pointer of zero
// degenerates to fixed lowest-index priority.
module nn_rr_pick
   import nn_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [OWNER_W-1:0] ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [OWNER_W-1:0] idx,
   output logic               any
);

   logic [NUM_REQ-1:0] mask;
   logic [NUM_REQ-1:0] masked;
   logic [NUM_REQ-1:0] cand;

   // Positions at or above the pointer are searched first.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign mask[gi] = (OWNER_W'(gi) >= ptr);
   end

   assign masked = req & mask;
   assign cand   = (|masked) ? masked : req;
   assign onehot = cand & (~cand + NUM_REQ'(1));
   assign any    = |req;

   // Encode the isolated one-hot winner into an index.
   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (onehot[i]) idx = OWNER_W'(i);
      end
   end

endmodule

// File: rtl/nn_step_scheduler.sv
// Step scheduler: grants one requester at a time and walks it through
// NUM_STEPS steps (GRANT -> RUN -> DONE), with hold freezing the step and
// an abort when the owner withdraws its request.
// Optional feature: define NN_SCHED_RR_EN for round-robin arbitration;
// otherwise the lowest requester index always wins.
module nn_step_scheduler
   import nn_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int NUM_STEPS = 16
) (
   input  logic              clk,
   input  logic              rst,
   nn_step_scheduler_if.slave bus
);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

   state_t              state_reg, state_next;
   logic [STEP_W-1:0]   step_reg, step_next;
   logic [OWNER_W-1:0]  owner_reg, owner_next;
   logic [NUM_REQ-1:0]  gnt_reg, gnt_next;
   logic                aborted_reg, aborted_next;

   logic [NUM_REQ-1:0]  pick_onehot;
   logic [OWNER_W-1:0]  pick_idx;
   logic                pick_any;
   logic [OWNER_W-1:0]  ptr;
   logic                owner_req;

   nn_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (bus.req),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // The owner still wants the job; gnt_reg is one-hot on the owner.
   assign owner_req = |(bus.req & gnt_reg);

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         step_reg    <= '0;
         owner_reg   <= '0;
         gnt_reg     <= '0;
         aborted_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         step_reg    <= step_next;
         owner_reg   <= owner_next;
         gnt_reg     <= gnt_next;
         aborted_reg <= aborted_next;
      end
   end

   // Next-state logic: arbitration, step advance, completion and abort.
   always_comb begin
      state_next   = state_reg;
      step_next    = step_reg;
      owner_next   = owner_reg;
      gnt_next     = gnt_reg;
      aborted_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_any) begin
               state_next = GRANT;
               owner_next = pick_idx;
               gnt_next   = pick_onehot;
               step_next  = '0;
            end
         end
         GRANT, RUN: begin
            if (!owner_req) begin
               // Owner withdrew: drop the job, pulse aborted in IDLE.
               state_next   = IDLE;
               step_next    = '0;
               owner_next   = '0;
               gnt_next     = '0;
               aborted_next = 1'b1;
            end else if (state_reg == GRANT) begin
               state_next = RUN;
               step_next  = '0;
            end else if (!bus.hold) begin
               if (step_reg == LAST_STEP) begin
                  state_next = DONE;
                  step_next  = '0;
               end else begin
                  step_next = step_reg + STEP_W'(1);
               end
            end
         end
         DONE: begin
            // Request changes are ignored here; the job always completes.
            state_next = IDLE;
            owner_next = '0;
            gnt_next   = '0;
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef NN_SCHED_RR_EN
   logic [OWNER_W-1:0] ptr_reg;
   logic               ptr_update;

   assign ptr_update = (state_reg == DONE) ||
                       (((state_reg == GRANT) || (state_reg == RUN)) && !owner_req);

   // Round-robin pointer: search starts just past the owner that finished.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg <= '0;
      end else if (ptr_update) begin
         ptr_reg <= (owner_reg == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_reg + OWNER_W'(1);
      end
   end

   assign ptr = ptr_reg;
`else
   assign ptr = '0;
`endif

   assign bus.gnt        = gnt_reg;
   assign bus.owner      = owner_reg;
   assign bus.step       = step_reg;
   assign bus.step_valid = (state_reg == RUN);
   assign bus.done       = (state_reg == DONE);
   assign bus.aborted    = aborted_reg;

endmodule

// File: tb/tb_nn_step_scheduler.sv
// Self-checking bench for nn_step_scheduler: a job-level model checked on
// every cycle plus directed scenarios with hand-computed expectations.
module tb_nn_step_scheduler;
   import nn_pkg::*;

   localparam int NR = 4;
   localparam int NS = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   nn_step_scheduler_if #(.NUM_REQ(NR)) bus ();

   nn_step_scheduler #(.NUM_REQ(NR), .NUM_STEPS(NS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Job-level model: owner index (-1 idle) and position in the job
   // (-1 grant cycle, 0..NS-1 run steps, NS completion cycle).
   int m_owner   = -1;
   int m_pos     = 0;
   int m_ptr     = 0;
   bit m_aborted = 1'b0;

   function automatic int pick_winner(logic [NR-1:0] r, int p);
      for (int k = 0; k < NR; k++) begin
         int c;
         c = (p + k) % NR;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic mdl_reset();
      m_owner = -1; m_pos = 0; m_ptr = 0; m_aborted = 1'b0;
   endtask

   task automatic mdl_release();
`ifdef NN_SCHED_RR_EN
      m_ptr = (m_owner + 1) % NR;
`endif
      m_owner = -1;
      m_pos   = 0;
   endtask

   task automatic mdl_step(logic [NR-1:0] r, logic h);
      m_aborted = 1'b0;
      if (m_owner < 0) begin
         int w;
         w = pick_winner(r, m_ptr);
         if (w >= 0) begin m_owner = w; m_pos = -1; end
      end else if (m_pos == NS) begin
         mdl_release();
      end else if (!r[m_owner]) begin
         mdl_release();
         m_aborted = 1'b1;
      end else if (m_pos < 0) begin
         m_pos = 0;
      end else if (!h) begin
         m_pos++;
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Per-cycle compare against the model, sampled on the falling edge.
   int cyc = 0;
   initial begin
      forever begin
         @(posedge clk);
         if (rst) mdl_reset();
         else mdl_step(bus.req, bus.hold);
         @(negedge clk);
         cyc++;
         if (rst) mdl_reset();
         begin
            bit busy, run;
            busy = (m_owner >= 0);
            run  = busy && (m_pos >= 0) && (m_pos < NS);
            chk($sformatf("gnt@%0d", cyc), 32'(bus.gnt), busy ? (32'd1 << m_owner) : 32'd0);
            chk($sformatf("owner@%0d", cyc), 32'(bus.owner), busy ? 32'(m_owner) : 32'd0);
            chk($sformatf("step@%0d", cyc), 32'(bus.step), run ? 32'(m_pos) : 32'd0);
            chk($sformatf("step_valid@%0d", cyc), 32'(bus.step_valid), 32'(run));
            chk($sformatf("done@%0d", cyc), 32'(bus.done), 32'(busy && (m_pos == NS)));
            chk($sformatf("aborted@%0d", cyc), 32'(bus.aborted), 32'(m_aborted));
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      bus.req  = '0;
      bus.hold = 1'b0;
      tick(2);
      rst = 1'b0;
   endtask

   int own [5];

   initial begin
      bus.req  = '0;
      bus.hold = 1'b0;
      tick(3);
      chk("rst gnt", 32'(bus.gnt), 32'd0);
      chk("rst owner", 32'(bus.owner), 32'd0);
      chk("rst step", 32'(bus.step), 32'd0);
      chk("rst step_valid", 32'(bus.step_valid), 32'd0);
      chk("rst done", 32'(bus.done), 32'd0);
      chk("rst aborted", 32'(bus.aborted), 32'd0);
      rst = 1'b0;
      $display("txn basic job req=0010");

      // Basic job, owner drops req during DONE (completion unaffected).
      bus.req = 4'b0010;
      tick(1);
      chk("basic gnt c1", 32'(bus.gnt), 32'b0010);
      chk("basic step_valid c1", 32'(bus.step_valid), 32'd0);
      tick(1);
      chk("basic step c2", 32'(bus.step), 32'd0);
      chk("basic step_valid c2", 32'(bus.step_valid), 32'd1);
      tick(15);
      chk("basic step c17", 32'(bus.step), 32'd15);
      tick(1);
      chk("basic done c18", 32'(bus.done), 32'd1);
      chk("basic gnt c18", 32'(bus.gnt), 32'b0010);
      bus.req = 4'b0000;
      tick(1);
      chk("basic gnt c19", 32'(bus.gnt), 32'd0);
      chk("basic aborted c19", 32'(bus.aborted), 32'd0);

      // All requesters held: arbitration order over five jobs.
      $display("txn arbitration req=1111");
      do_reset();
      bus.req = 4'b1111;
      tick(1);
      own[0] = int'(bus.owner);
      for (int j = 1; j < 5; j++) begin
         tick(19);
         own[j] = int'(bus.owner);
      end
      for (int j = 0; j < 5; j++) begin
`ifdef NN_SCHED_RR_EN
         chk($sformatf("arb owner job%0d", j), 32'(own[j]), 32'(j % NR));
`else
         chk($sformatf("arb owner job%0d", j), 32'(own[j]), 32'd0);
`endif
      end
      tick(17);
      bus.req = '0;
      tick(2);

      // Hold for three cycles at step 5.
      $display("txn hold at step 5");
      do_reset();
      bus.req = 4'b0001;
      tick(7);
      chk("hold step c7", 32'(bus.step), 32'd5);
      bus.hold = 1'b1;
      tick(3);
      chk("hold step c10", 32'(bus.step), 32'd5);
      bus.hold = 1'b0;
      tick(1);
      chk("hold step c11", 32'(bus.step), 32'd6);
      tick(7);
      chk("hold done c18", 32'(bus.done), 32'd0);
      chk("hold step c18", 32'(bus.step), 32'd13);
      tick(3);
      chk("hold done c21", 32'(bus.done), 32'd1);
      bus.req = '0;
      tick(2);

      // Owner 2 withdraws at step 7.
      $display("txn abort owner 2 at step 7");
      do_reset();
      bus.req = 4'b1100;
      tick(1);
      chk("abort owner c1", 32'(bus.owner), 32'd2);
      tick(8);
      chk("abort step c9", 32'(bus.step), 32'd7);
      bus.req = 4'b1001;
      tick(1);
      chk("abort aborted c10", 32'(bus.aborted), 32'd1);
      chk("abort done c10", 32'(bus.done), 32'd0);
      chk("abort step c10", 32'(bus.step), 32'd0);
      chk("abort gnt c10", 32'(bus.gnt), 32'd0);
      tick(1);
`ifdef NN_SCHED_RR_EN
      chk("abort next owner c11", 32'(bus.owner), 32'd3);
`else
      chk("abort next owner c11", 32'(bus.owner), 32'd0);
`endif
      chk("abort aborted c11", 32'(bus.aborted), 32'd0);
      bus.req = '0;
      tick(2);

      // Asynchronous reset mid-job at step 9, then a fresh job.
      $display("txn async reset at step 9");
      do_reset();
      bus.req = 4'b0001;
      tick(11);
      chk("arst step c11", 32'(bus.step), 32'd9);
      #2 rst = 1'b1;
      #1;
      chk("arst gnt", 32'(bus.gnt), 32'd0);
      chk("arst owner", 32'(bus.owner), 32'd0);
      chk("arst step", 32'(bus.step), 32'd0);
      chk("arst step_valid", 32'(bus.step_valid), 32'd0);
      tick(1);
      chk("arst done", 32'(bus.done), 32'd0);
      chk("arst aborted", 32'(bus.aborted), 32'd0);
      rst = 1'b0;
      tick(1);
      chk("arst regrant gnt", 32'(bus.gnt), 32'b0001);
      tick(17);
      chk("arst regrant done", 32'(bus.done), 32'd1);
      bus.req = '0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nn_step_scheduler.md
NN_STEP_SCHEDULER -- requirements
Module: nn_step_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the step sequencer (2..8).
REQ-002 SHALL have parameter NUM_STEPS, default 16: steps per granted job (2..32).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester job request, level.
REQ-006 SHALL have port hold  input  1  freeze step advance while high.
REQ-007 SHALL have port gnt  output  NUM_REQ  one-hot grant, zero when idle.
REQ-008 SHALL have port owner  output  3  index of granted requester, 0 when idle.
REQ-009 SHALL have port step  output  5  current step index 0..NUM_STEPS-1, zero-extended.
REQ-010 SHALL have port step_valid  output  1  high in RUN while step is meaningful.
REQ-011 SHALL have port done  output  1  one-cycle pulse on job completion.
REQ-012 SHALL have port aborted  output  1  one-cycle pulse when owner drops req mid-job.

Function
REQ-013 SHALL implement states IDLE, GRANT, RUN, DONE.
REQ-014 IDLE: if any req bit set at edge, SHALL select winner, go to GRANT; gnt/owner valid from GRANT onward.
REQ-015 GRANT: SHALL last exactly one cycle, step=0, step_valid=0; next state RUN.
REQ-016 RUN: step_valid=1; step SHALL increment by 1 per cycle when hold=0, hold its value when hold=1.
REQ-017 RUN with step=NUM_STEPS-1 and hold=0 SHALL go to DONE; step never exceeds NUM_STEPS-1.
REQ-018 DONE: one cycle, done=1, gnt still asserted, step_valid=0; next state IDLE, gnt cleared.
REQ-019 Owner's req low in GRANT or RUN SHALL go to IDLE next cycle with aborted=1 for that cycle, step cleared, done not asserted.
REQ-020 Owner's req low in DONE SHALL be ignored (job completes normally).
REQ-021 Non-owner req changes SHALL NOT affect an active job; no preemption.
REQ-022 Minimum spacing between two grants SHALL be one IDLE cycle after DONE/abort.
REQ-023 Latency: req rising in IDLE -> gnt next cycle -> step 0 valid the cycle after; job with hold=0 occupies NUM_STEPS+2 cycles incl. GRANT and DONE.
REQ-024 done and aborted SHALL never be high in the same cycle.

Reset
REQ-025 rst high SHALL force IDLE immediately, regardless of clk: gnt=0, owner=0, step=0, step_valid=0, done=0, aborted=0, RR pointer=0.
REQ-026 rst mid-job SHALL drop the job silently (no done, no aborted pulse).

Configuration
REQ-027 With NN_SCHED_RR_EN defined: round-robin; search starts at (last owner+1) mod NUM_REQ; pointer updates on DONE or abort.
REQ-028 Without NN_SCHED_RR_EN: fixed priority, lowest index wins; no pointer register.

Structure
REQ-029 Shared package nn_pkg SHALL hold the state enum typedef and STEP_W=5, OWNER_W=3 constants.
REQ-030 Winner selection SHALL be a sub-module nn_rr_pick (req, pointer -> one-hot + index), combinational; pointer input tied 0 without macro.

Verification
REQ-031 req=4'b0010, hold=0 -> gnt=0010 cycle 1, step 0..15 cycles 2..17, done cycle 18, gnt=0 cycle 19.
REQ-032 req=4'b1111 held, RR on -> owners 0,1,2,3,0 in order; RR off -> owner 0 every job.
REQ-033 hold=1 for 3 cycles at step=5 -> step stays 5 for 3 cycles, done delayed 3 cycles.
REQ-034 owner 2 drops req at step=7 -> aborted pulse next cycle, no done, step=0, next grant goes to owner 3 (RR on).
REQ-035 rst asserted at step=9 -> all outputs zero asynchronously, no done/aborted; after release req=0001 -> normal job.
REQ-036 owner drops req during DONE -> done still pulses, aborted stays 0.
